// File: rtl/port_out_fifo_pkg.sv
// Shared status-bit positions (also used by the firmware assembler) and a helper
// that packs the status byte read back through an ein input.
`ifndef PORT_OUT_FIFO_DEFS
`define PORT_OUT_FIFO_DEFS
`define PORT_ST_EMPTY   0
`define PORT_ST_FULL    1
`define PORT_ST_OVF     2
`define PORT_ST_CNT_LSB 4
`endif

package port_out_fifo_pkg;

  localparam int StEmpty  = `PORT_ST_EMPTY;
  localparam int StFull   = `PORT_ST_FULL;
  localparam int StOvf    = `PORT_ST_OVF;
  localparam int StCntLsb = `PORT_ST_CNT_LSB;

  // Bit 3 is reserved and always reads as zero.
  function automatic logic [7:0] packStatus(input logic empty, input logic full,
                                            input logic ovf, input logic [3:0] count);
    logic [7:0] s;
    s                      = 8'h00;
    s[StEmpty]             = empty;
    s[StFull]              = full;
    s[StOvf]               = ovf;
    s[StCntLsb+3:StCntLsb] = count;
    return s;
  endfunction

endpackage

// File: rtl/port_out_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port and one combinational
// read port, cleared by the asynchronous reset.
module fifo_mem
  import port_out_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign rd = r_mem[ra];

endmodule

// File: rtl/port_out_fifo.sv
// Consumer of a microcontroller port write: queues written bytes, drains them with
// valid/ready, and reports empty/full/overflow/count as a pollable status byte.
module port_out_fifo
  import port_out_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  input  logic       ext_ready,
  output logic       ext_valid,
  output logic [7:0] ext_data,
  output logic [7:0] status
);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_ovfEvent;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & ext_ready;
  // A full queue still accepts a write when the same cycle frees a slot.
  assign w_push     = wr_en & (~w_full | w_pop);
  assign w_ovfEvent = wr_en & w_full & ~w_pop;

  fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (w_push),
    .wa    (r_wrPtr),
    .wd    (wr_data),
    .ra    (r_rdPtr),
    .rd    (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overflow: a new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_ovf <= 1'b0;
    else if (w_ovfEvent) r_ovf <= 1'b1;
    else if (clr_ovf)    r_ovf <= 1'b0;
  end

  assign ext_valid = ~w_empty;
  assign status    = packStatus(w_empty, w_full, r_ovf, 4'(r_count));

endmodule

// File: tb/tb_port_out_fifo.sv
// Directed bench for port_out_fifo: inputs change on the falling edge, outputs are
// checked on the following falling edge against hand-computed values.
module tb_port_out_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       ext_ready;
  logic       ext_valid;
  logic [7:0] ext_data;
  logic [7:0] status;

  int errors = 0;
  int checks = 0;

  port_out_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .ext_ready (ext_ready),
    .ext_valid (ext_valid),
    .ext_data  (ext_data),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; ext_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (status !== 8'h01 || ext_valid !== 1'b0 || ext_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_init: status=%h valid=%b data=%h, required 01/0/00", status, ext_valid, ext_data);
    end
    reset = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (ext_valid !== 1'b1 || ext_data !== 8'h3C || status !== 8'h10) begin
      errors++;
      $display("[TB] FAIL reset_prewrite: valid=%b data=%h status=%h, required 1/3c/10", ext_valid, ext_data, status);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ext_valid !== 1'b0 || status !== 8'h01 || ext_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: valid=%b status=%h data=%h, required 0/01/00", ext_valid, status, ext_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] fillBytes [4];
    fillBytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    ext_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = fillBytes[i];
      @(negedge clk);
      checks++;
      if (status !== (8'((i + 1) << 4) | (i == 3 ? 8'h02 : 8'h00))) begin
        errors++;
        $display("[TB] FAIL fill_status_%0d: status=%h", i, status);
      end
    end
    wr_en = 1'b0;
    checks++;
    if (status !== 8'h42 || ext_data !== 8'hA1 || ext_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_full: status=%h data=%h valid=%b, required 42/a1/1", status, ext_data, ext_valid);
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (status !== 8'h46 || ext_data !== 8'hA1) begin
      errors++;
      $display("[TB] FAIL ovf_set: status=%h data=%h, required 46/a1", status, ext_data);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (status !== 8'h42) begin
      errors++;
      $display("[TB] FAIL ovf_clear: status=%h, required 42", status);
    end
    wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clr_ovf = 1'b0;
    checks++;
    if (status !== 8'h46) begin
      errors++;
      $display("[TB] FAIL ovf_set_wins: status=%h, required 46", status);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (status !== 8'h42 || ext_data !== 8'hA1) begin
      errors++;
      $display("[TB] FAIL ovf_reclear: status=%h data=%h, required 42/a1", status, ext_data);
    end
  endtask

  task automatic drain4(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input string tag);
    logic [7:0] exp [4];
    exp = '{b0, b1, b2, b3};
    ext_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ext_valid !== 1'b1 || ext_data !== exp[i]) begin
        errors++;
        $display("[TB] FAIL %s_byte%0d: valid=%b data=%h, required 1/%h", tag, i, ext_valid, ext_data, exp[i]);
      end
      @(negedge clk);
    end
    ext_ready = 1'b0;
    checks++;
    if (ext_valid !== 1'b0 || status !== 8'h01) begin
      errors++;
      $display("[TB] FAIL %s_empty: valid=%b status=%h, required 0/01", tag, ext_valid, status);
    end
  endtask

  task automatic test_drain();
    drain4(8'hA1, 8'hA2, 8'hA3, 8'hA4, "drain");
  endtask

  task automatic test_back_to_back();
    // Empty queue with a write and ready together: no bypass, the byte is stored.
    wr_en = 1'b1; wr_data = 8'h77; ext_ready = 1'b1;
    #1;
    checks++;
    if (ext_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_nobypass: valid=%b, required 0", ext_valid);
    end
    @(negedge clk);
    wr_en = 1'b0; ext_ready = 1'b0;
    checks++;
    if (status !== 8'h10 || ext_data !== 8'h77) begin
      errors++;
      $display("[TB] FAIL empty_store: status=%h data=%h, required 10/77", status, ext_data);
    end
    ext_ready = 1'b1;
    @(negedge clk);
    ext_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b1; wr_data = 8'h55; ext_ready = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ext_ready = 1'b0;
    checks++;
    if (status !== 8'h42 || ext_data !== 8'hA2) begin
      errors++;
      $display("[TB] FAIL full_pushpop: status=%h data=%h, required 42/a2", status, ext_data);
    end
    drain4(8'hA2, 8'hA3, 8'hA4, 8'h55, "pushpop");
  endtask

  task automatic test_wrap();
    ext_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      @(negedge clk);
      checks++;
      if (ext_data !== 8'h30 + 8'(i) || status !== 8'h10) begin
        errors++;
        $display("[TB] FAIL wrap_%0d: data=%h status=%h, required %h/10", i, ext_data, status, 8'h30 + 8'(i));
      end
    end
    wr_en = 1'b0;
    @(negedge clk);
    ext_ready = 1'b0;
    checks++;
    if (status !== 8'h01 || ext_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_empty: status=%h valid=%b, required 01/0", status, ext_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
